// File: rtl/mm_pkg.sv
// Shared types for the mm datapath: ALU opcodes and the alu_mc FSM state encoding.
package mm;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MULT = 3'd2,
    OP_DIV  = 3'd3
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    HOLD     = 2'd2
  } alu_state_e;

endpackage

// File: rtl/div_iter.sv
// Restoring divider on unsigned WIDTH-bit magnitudes; one quotient bit per cycle.
module div_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo_reg, rem_reg, dvs_reg;
  logic [CW-1:0]    count_reg;
  logic             busy_reg, done_reg;
  logic [WIDTH:0]   shifted, trial;
  logic             fits;

  // The quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  always_comb begin
    shifted = {rem_reg, quo_reg[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_reg};
    fits    = ~trial[WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        quo_reg   <= dividend;
        rem_reg   <= '0;
        dvs_reg   <= divisor;
        count_reg <= CW'(WIDTH);
        busy_reg  <= 1'b1;
      end else if (busy_reg) begin
        quo_reg   <= {quo_reg[WIDTH-2:0], fits};
        rem_reg   <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        count_reg <= count_reg - 1'b1;
        if (count_reg == CW'(1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU: single-cycle ADD/SUB/MULT, iterative signed/unsigned DIV.
module alu_mc
  import mm::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  opcode_e          opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             ovf,
  output logic             err
);

  localparam logic SGN = (SIGNED != 0);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  alu_state_e state_reg, state_next;
  logic [WIDTH-1:0] out_reg, out_hi_reg;
  logic             ovf_reg, err_reg;
  logic             q_neg_reg, r_neg_reg, min_ovf_reg;

  logic [WIDTH:0]     sum, dif;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   res_out, res_hi, div_q, div_r;
  logic               res_ovf, res_err, accept, div_start;
  logic               div_busy, div_done;
  logic [WIDTH-1:0]   div_quo, div_rem;

  always_comb begin
    sum   = {1'b0, operand1} + {1'b0, operand2};
    dif   = {1'b0, operand1} - {1'b0, operand2};
    a_ext = SGN ? {{WIDTH{operand1[WIDTH-1]}}, operand1} : {{WIDTH{1'b0}}, operand1};
    b_ext = SGN ? {{WIDTH{operand2[WIDTH-1]}}, operand2} : {{WIDTH{1'b0}}, operand2};
    prod  = a_ext * b_ext;
    a_neg = SGN & operand1[WIDTH-1];
    b_neg = SGN & operand2[WIDTH-1];
    a_mag = a_neg ? (~operand1 + 1'b1) : operand1;
    b_mag = b_neg ? (~operand2 + 1'b1) : operand2;
  end

  // Results that are ready at accept time; a legal DIV leaves these unused.
  always_comb begin
    res_out = '0;
    res_hi  = '0;
    res_ovf = 1'b0;
    res_err = 1'b0;
    case (opcode)
      OP_ADD: begin
        res_out = sum[WIDTH-1:0];
        res_ovf = SGN ? ((operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                         (sum[WIDTH-1] != operand1[WIDTH-1]))
                      : sum[WIDTH];
      end
      OP_SUB: begin
        res_out = dif[WIDTH-1:0];
        res_ovf = SGN ? ((operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                         (dif[WIDTH-1] != operand1[WIDTH-1]))
                      : dif[WIDTH];
      end
      OP_MULT: begin
        res_out = prod[WIDTH-1:0];
        res_hi  = prod[2*WIDTH-1:WIDTH];
        res_ovf = SGN ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                      : (|prod[2*WIDTH-1:WIDTH]);
      end
      OP_DIV: begin
        if (operand2 == '0) begin
          res_out = '1;
          res_hi  = operand1;
          res_err = 1'b1;
        end
      end
      default: res_err = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    div_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          accept = 1'b1;
          if (opcode == OP_DIV && operand2 != '0) begin
            div_start  = 1'b1;
            state_next = DIV_BUSY;
          end else begin
            state_next = HOLD;
          end
        end
      end
      DIV_BUSY: begin
        if (div_done)       state_next = HOLD;
        else if (!div_busy) state_next = IDLE;
      end
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // MIN / -1 needs no special datapath: the unsigned magnitude quotient is already MIN.
  assign div_q = q_neg_reg ? (~div_quo + 1'b1) : div_quo;
  assign div_r = r_neg_reg ? (~div_rem + 1'b1) : div_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg     <= '0;
      out_hi_reg  <= '0;
      ovf_reg     <= 1'b0;
      err_reg     <= 1'b0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      min_ovf_reg <= 1'b0;
    end else if (accept && !div_start) begin
      out_reg    <= res_out;
      out_hi_reg <= res_hi;
      ovf_reg    <= res_ovf;
      err_reg    <= res_err;
    end else if (div_start) begin
      q_neg_reg   <= a_neg ^ b_neg;
      r_neg_reg   <= a_neg;
      min_ovf_reg <= SGN && (operand1 == MIN_VAL) && (operand2 == '1);
    end else if (state_reg == DIV_BUSY && div_done) begin
      out_reg    <= div_q;
      out_hi_reg <= div_r;
      ovf_reg    <= min_ovf_reg;
      err_reg    <= 1'b0;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == HOLD);
  assign out       = out_reg;
  assign out_hi    = out_hi_reg;
  assign ovf       = ovf_reg;
  assign err       = err_reg;

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle, handshaked ALU for the `mm` datapath. It accepts one operation at a time over a valid/ready input port and returns a registered result with status flags over a valid/ready output port. ADD, SUB and MULT complete in one cycle; DIV runs through an iterative divider. Operand width and signedness are parameters. It sits between the operand sequencer and the writeback stage, and supports backpressure from writeback.

## Interface
- `WIDTH`, default 8: operand and result width in bits, ≥ 2.
- `SIGNED`, default 1: 1 = two's-complement operands, 0 = unsigned.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: an operation is presented.
- `in_ready` out 1: the block can accept an operation.
- `opcode` in `opcode_e`: ADD, SUB, MULT, DIV.
- `operand1` in WIDTH: A (dividend for DIV).
- `operand2` in WIDTH: B (divisor for DIV).
- `out_valid` out 1: result is held on the outputs.
- `out_ready` in 1: downstream takes the result.
- `out` out WIDTH: primary result (sum, difference, low product, quotient).
- `out_hi` out WIDTH: high product half (MULT), remainder (DIV), 0 otherwise.
- `ovf` out 1: overflow.
- `err` out 1: divide-by-zero or illegal opcode.

## Operation
- FSM states: IDLE, DIV_BUSY, HOLD.
- Accept: a handshake occurs on the edge where `in_valid && in_ready`. `in_ready` = (state == IDLE). Inputs are captured on that edge; later changes to the inputs are ignored.
- IDLE transitions:
  - ADD, SUB, MULT, divide-by-zero DIV, illegal opcode: go to HOLD with the result registered.
  - Legal DIV: go to DIV_BUSY.
- DIV_BUSY: one quotient bit per cycle. After WIDTH iterations, go to HOLD.
- HOLD: `out_valid` = 1. On the edge where `out_ready` = 1, go to IDLE. Outputs stay stable while `out_ready` = 0.
- Arithmetic:
  - ADD/SUB: `out` = A ± B mod 2^WIDTH, `out_hi` = 0. `ovf` = signed overflow when SIGNED = 1, carry/borrow out when SIGNED = 0.
  - MULT: the full 2·WIDTH product is split as {`out_hi`, `out`}. `ovf` = 1 when the product does not fit in WIDTH bits (signed: `out_hi` is not the sign extension of `out`).
  - DIV: magnitudes are divided and the result truncates toward zero. Quotient sign = sign(A) xor sign(B); remainder takes the sign of A.
  - DIV with B = 0: `out` = all ones, `out_hi` = A, `err` = 1, latency 1.
  - Signed MIN / −1: `out` = MIN, `out_hi` = 0, `ovf` = 1.
  - Illegal opcode value: `out` = `out_hi` = 0, `err` = 1.
- Flags are registered with the result and valid only while `out_valid` = 1.

## Timing
- Reset (asynchronous, any state including mid-divide): state goes to IDLE and the divider is cleared. `in_ready` = 1 combinationally from IDLE. `out_valid`, `out`, `out_hi`, `ovf`, `err` all = 0.
- Single-cycle ops: accepted at edge N, `out_valid` = 1 after edge N.
- Legal DIV: accepted at edge N, `out_valid` = 1 after edge N+WIDTH+1.
- Throughput: at most one operation per 2 cycles. `in_ready` is 0 during HOLD, including the cycle in which `out_ready` is 1. A new accept is possible at the edge after the output handshake.
- `in_valid` while `in_ready` = 0: no effect. The source must hold its request.

## Structure
- Package `mm`: `opcode_e` (existing), plus a `alu_state_e` enum for IDLE/DIV_BUSY/HOLD, shared so benches can probe the state.
- Sub-module `div_iter`: restoring divider on WIDTH-bit unsigned magnitudes.
  - Ports: start, busy, done, quotient, remainder.
  - Sign correction and the zero/MIN cases are handled in `alu_mc`.
- `alu_mc` holds the FSM, the single-cycle datapath, sign handling and the output registers.

## Test plan
- Reset during DIV_BUSY, mid-divide: outputs go to 0 immediately. `in_ready` = 1 after reset release. The next ADD 3+4 gives `out` = 7.
- WIDTH=8, SIGNED=1, ADD 100+100: `out` = 0xC8, `ovf` = 1, `out_valid` one edge after accept.
- WIDTH=8, SIGNED=1, MULT −7×9: `out_hi`:`out` = 0xFF:0xC1, `ovf` = 0. Then MULT 16×16: `out` = 0x00, `out_hi` = 0x01, `ovf` = 1.
- WIDTH=8, SIGNED=1, DIV −17/5: `out` = −3, `out_hi` = −2, `out_valid` exactly 9 edges after accept.
- DIV 42/0: `out` = 0xFF, `out_hi` = 42, `err` = 1 after 1 edge. DIV −128/−1: `out` = 0x80, `ovf` = 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles. Result and flags stay stable, `in_ready` = 0, and a second request is ignored until the handshake. SIGNED=0, WIDTH=16: DIV 65535/256 gives `out` = 255, `out_hi` = 255.
